// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter (request-to-send, device-clocked shift-out, ACK check)
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       btnC,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       PS2Clk_in,
    input  logic       data_in,
    output logic       PS2Clk_drive_low,
    output logic       data_drive_low
);
    typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE, DONE, ERR} state_t;
    localparam int CW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);
    state_t state, state_n;
    logic [1:0] s1, s2, filt;
    logic [FW-1:0] fcnt [2];
    logic clk_fd, clk_fall, timeout, data_low;
    logic [10:0] frame;
    logic [3:0] bitcnt;
    logic [CW-1:0] count;
    logic [TW-1:0] timer;
    assign clk_fall = clk_fd & ~filt[0];
    assign timeout = timer == TW'(TIMEOUT_CYCLES);
    // bit 0 carries PS2Clk, bit 1 carries data; lines idle high
    always_ff @(posedge clk) begin
        if (!btnC) begin
            s1 <= '1;
            s2 <= '1;
            filt <= '1;
            fcnt <= '{default: '0};
            clk_fd <= 1'b1;
        end else begin
            s1 <= {data_in, PS2Clk_in};
            s2 <= s1;
            clk_fd <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == filt[i]) fcnt[i] <= '0;
                else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
                    filt[i] <= s2[i];
                    fcnt[i] <= '0;
                end else fcnt[i] <= fcnt[i] + FW'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!btnC) begin
            state <= IDLE;
            frame <= '0;
            bitcnt <= '0;
            count <= '0;
            timer <= '0;
            data_low <= 1'b0;
        end else begin
            state <= state_n;
            count <= (state == INHIBIT) ? count + CW'(1) : '0;
            timer <= (clk_fall || !(state inside {SEND, ACK, WAIT_IDLE})) ? '0 : timer + TW'(1);
            if (state == IDLE && tx_valid) frame <= {1'b1, ~^tx_data, tx_data, 1'b0};
            if (state == START) begin
                bitcnt <= 4'd1;
                data_low <= 1'b1;
            end else if (state == SEND && clk_fall) begin
                data_low <= ~frame[bitcnt];
                bitcnt <= bitcnt + 4'd1;
            end else if (state != SEND) data_low <= 1'b0;
        end
    end
    // a device clk_fall during INHIBIT/START is deliberately ignored: host inhibit wins
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = tx_valid ? INHIBIT : IDLE;
            INHIBIT:   state_n = (count == CW'(INHIBIT_CYCLES - 1)) ? START : INHIBIT;
            START:     state_n = SEND;
            SEND:      state_n = timeout ? ERR : (clk_fall && bitcnt == 4'd10) ? ACK : SEND;
            ACK:       state_n = timeout ? ERR : clk_fall ? (filt[1] ? ERR : WAIT_IDLE) : ACK;
            WAIT_IDLE: state_n = timeout ? ERR : (filt == 2'b11) ? DONE : WAIT_IDLE;
            default:   state_n = IDLE;
        endcase
        tx_ready = state == IDLE;
        busy = state != IDLE;
        tx_done = state == DONE;
        tx_error = state == ERR;
        PS2Clk_drive_low = state inside {INHIBIT, START};
        data_drive_low = (state == START) || (state == SEND && data_low);
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. The opposite direction of the existing keyboard receiver.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs followed by an LED mask, or 0xFF reset.
- Generates the request-to-send sequence on the shared PS2Clk/data lines, shifts the frame out on device-generated clocks, and checks the device ACK.
- Sits beside the keyboard receiver in top. Top converts the drive-low outputs to open-drain: line = drive_low ? 0 : z.

Parameters:
- INHIBIT_CYCLES, 12000, clk cycles PS2Clk is held low before the start bit (120 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000, max clk cycles allowed between device clock falling edges, and waiting for bus idle (20 ms).
- FILTER_LEN, 8, consecutive equal samples required before the filtered PS2Clk/data change value.

Ports:
- clk  in  1  board clock, 100 MHz
- btnC  in  1  synchronous active-low reset
- tx_data  in  8  byte to send
- tx_valid  in  1  request; accepted when tx_valid && tx_ready
- tx_ready  out  1  high only in IDLE
- busy  out  1  high from acceptance until DONE/ERR; top uses it to gate the receiver's flag_1
- tx_done  out  1  1-cycle pulse: frame sent and ACK seen
- tx_error  out  1  1-cycle pulse: NACK or timeout
- PS2Clk_in  in  1  sampled PS2Clk line
- data_in  in  1  sampled PS2 data line
- PS2Clk_drive_low  out  1  1 = pull PS2Clk low
- data_drive_low  out  1  1 = pull data low

Behaviour:
- Clock and reset:
  - Single clock domain.
  - btnC=0 at a posedge: all state clears at that edge. Reset values: state=IDLE, tx_ready=1, busy=0, tx_done=0, tx_error=0, both drive_low=0, counters=0.
  - Reset mid-frame releases both lines at that edge. No partial frame resumes.
- Input conditioning:
  - PS2Clk_in and data_in each pass a 2-FF synchronizer, then a FILTER_LEN glitch filter.
  - clk_fall = filtered clock registered 1 -> 0, one cycle wide.
- Frame register:
  - On acceptance: frame[10:0] = {1 stop, parity, tx_data[7:0], 0 start}.
  - parity = ~^tx_data (odd parity).
  - tx_ready drops in the cycle after acceptance. tx_valid while busy is ignored; there is no queue.
- States:
  - IDLE: tx_ready=1, lines released. On tx_valid: latch frame, count=0 -> INHIBIT.
  - INHIBIT: PS2Clk_drive_low=1. At count==INHIBIT_CYCLES-1 -> START.
  - START (1 cycle): PS2Clk_drive_low=1, data_drive_low=1 (start bit) -> SEND.
  - SEND: PS2Clk_drive_low=0, bitcnt=1, timer=0.
    - On each clk_fall: data_drive_low = ~frame[bitcnt], bitcnt++, timer=0.
    - Order: data bits 0..7 LSB first, then parity, then stop (stop releases data).
    - After the clk_fall that places the stop bit (bitcnt 10 -> 11) -> ACK.
  - ACK: data_drive_low=0. On next clk_fall, sample filtered data: 0 -> WAIT_IDLE; 1 -> ERR (NACK).
  - WAIT_IDLE: wait until filtered clock and data are both 1 -> DONE.
  - DONE (1 cycle): tx_done=1 -> IDLE.
  - ERR (1 cycle): tx_error=1, both lines released -> IDLE.
- Timeout: in SEND, ACK and WAIT_IDLE, timer counts clk cycles and resets on clk_fall. At timer==TIMEOUT_CYCLES -> ERR.
- Ordering: tx_done and tx_error are mutually exclusive and never co-assert with tx_ready. busy=1 in every state except IDLE.
- Bus contention: a clk_fall seen during INHIBIT/START (device was transmitting) is ignored. The host inhibit wins per protocol.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and ACKing -> data line after start reads 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulses once; busy falls the same cycle tx_ready rises.
- Send 0x02 -> bits 0,1,0,0,0,0,0,0, parity 0; PS2Clk_drive_low high for exactly 12000 cycles before data_drive_low rises; tx_done pulses.
- Device leaves data high at the ACK clock -> tx_error pulses, no tx_done, both drive_low outputs 0 next cycle.
- Device stops clocking after 4 falling edges -> tx_error exactly 2000000 cycles after the last clk_fall; lines released.
- btnC=0 during SEND bit 5 -> next edge: drive_low outputs 0, tx_ready=1, busy=0. A following 0xFF send completes normally.
- 3-cycle low glitch on PS2Clk_in during SEND -> no bit advance; frame content unchanged.
